// File: rtl/oam_dma.sv
// Sprite DMA ($4014): halts the CPU and copies page P ($P00-$PFF) into OAM through $2004.
// Optional macro OAM_DMA_ODD_ALIGN_EN inserts the odd-cycle ALIGN state; all state changes on the falling clock edge.
module oam_dma (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_rdy,
  output logic        o_dma_active,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data,
  output logic [8:0]  o_debug_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_page;
  logic [7:0]  r_index;
  logic [7:0]  r_byte;
  logic [8:0]  r_count;
  logic        r_parity;
  logic        w_trigger;

  // A $4014 write is only honoured while idle; later writes cannot retarget the page.
  assign w_trigger = (i_address == 16'h4014) && !i_rw && (r_state == S_IDLE);

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_next = S_HALT;
      S_HALT:  w_next = (ALIGN_EN && r_parity) ? S_ALIGN : S_READ;
      S_ALIGN: w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = (r_index == 8'hFF) ? S_IDLE : S_READ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_rdy        = 1'b0;
    o_dma_active = 1'b1;
    o_address    = 16'h0000;
    o_rw         = 1'b1;
    o_data       = 8'h00;
    case (r_state)
      S_IDLE: begin
        o_rdy        = 1'b1;
        o_dma_active = 1'b0;
      end
      S_HALT, S_ALIGN: o_address = {r_page, 8'h00};
      S_READ:          o_address = {r_page, r_index};
      S_WRITE: begin
        o_address = 16'h2004;
        o_rw      = 1'b0;
        o_data    = r_byte;
      end
      default: begin
        o_rdy        = 1'b1;
        o_dma_active = 1'b0;
      end
    endcase
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_page   <= 8'h00;
      r_index  <= 8'h00;
      r_byte   <= 8'h00;
      r_count  <= 9'd0;
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      if (w_trigger) begin
        r_page  <= i_data;
        r_index <= 8'h00;
        r_count <= 9'd0;
      end
      if (r_state == S_READ) begin
        r_byte <= i_bus_data;
      end
      if (r_state == S_WRITE) begin
        r_index <= r_index + 8'd1;
        r_count <= r_count + 9'd1;
      end
    end
  end

  assign o_debug_count = r_count;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected read addresses and OAM bytes are queued at trigger time,
// and a posedge monitor pops them whenever the DUT drives a $2004 write.
module tb_oam_dma;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_address;
  logic        i_rw;
  logic [7:0]  i_data;
  logic [7:0]  i_bus_data;
  logic        o_rdy;
  logic        o_dma_active;
  logic [15:0] o_address;
  logic        o_rw;
  logic [7:0]  o_data;
  logic [8:0]  o_debug_count;

  int chks = 0;
  int errs = 0;
  int halt_cnt = 0;
  int wr_seen = 0;
  int edge_cnt = 0;
  logic [15:0] last_rd = 16'h0;
  logic        rd_vld = 1'b0;
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_dat[$];

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam int ODD_HALT = 514;
`else
  localparam int ODD_HALT = 513;
`endif

  oam_dma dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_address(i_address), .i_rw(i_rw),
    .i_data(i_data), .i_bus_data(i_bus_data), .o_rdy(o_rdy),
    .o_dma_active(o_dma_active), .o_address(o_address), .o_rw(o_rw),
    .o_data(o_data), .o_debug_count(o_debug_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: page $02 holds i^$5A; other pages are distinct via the page byte.
  assign i_bus_data = o_address[7:0] ^ 8'h5A ^ o_address[15:8] ^ 8'h02;

  // Independent parity reference: number of falling edges since reset release.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!o_rdy) halt_cnt++;
    chk("rdy_vs_active", {31'd0, o_rdy}, {31'd0, ~o_dma_active});
    if (o_dma_active && o_rw) begin
      last_rd = o_address;
      rd_vld  = 1'b1;
    end else if (o_dma_active && !o_rw) begin
      wr_seen++;
      chk("wr_addr", {16'd0, o_address}, 32'h2004);
      if (exp_dat.size() == 0) begin
        chks++;
        errs++;
        $display("FAIL unexpected_write: got data %0h expected no write at %0t", o_data, $time);
      end else begin
        chk("rd_before_wr", {31'd0, rd_vld}, 32'd1);
        chk("rd_addr", {16'd0, last_rd}, {16'd0, exp_addr.pop_front()});
        chk("wr_data", {24'd0, o_data}, {24'd0, exp_dat.pop_front()});
      end
      rd_vld = 1'b0;
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    i_address = a; i_rw = 1'b0; i_data = d;
    @(posedge clk);
    i_address = 16'h0000; i_rw = 1'b1; i_data = 8'h00;
  endtask

  // Trigger so that the HALT cycle has the requested parity, then queue expectations.
  task automatic start_xfer(input logic [7:0] page, input int want_odd);
    int n = 0;
    @(posedge clk);
    while (((edge_cnt + 1) % 2) != want_odd && n < 4) begin
      @(posedge clk);
      n++;
    end
    for (int i = 0; i < 256; i++) begin
      exp_addr.push_back({page, i[7:0]});
      exp_dat.push_back(i[7:0] ^ 8'h5A ^ page ^ 8'h02);
    end
    halt_cnt = 0;
    wr_seen  = 0;
    cpu_write(16'h4014, page);
  endtask

  task automatic finish_xfer(input string name, input int exp_halt);
    int n = 0;
    while (!o_rdy && n < 700) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_done"}, {31'd0, o_rdy}, 32'd1);
    chk({name, "_halt_cycles"}, halt_cnt, exp_halt);
    chk({name, "_writes"}, wr_seen, 256);
    chk({name, "_count"}, {23'd0, o_debug_count}, 32'd256);
    chk({name, "_queue_empty"}, exp_dat.size(), 0);
    exp_dat.delete();
    exp_addr.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; i_address = 16'h0000; i_rw = 1'b1; i_data = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    chk("reset_rdy", {31'd0, o_rdy}, 32'd1);
    chk("reset_active", {31'd0, o_dma_active}, 32'd0);
    chk("reset_count", {23'd0, o_debug_count}, 32'd0);
    chk("reset_addr", {16'd0, o_address}, 32'd0);

    cpu_write(16'h4013, 8'h02);
    cpu_write(16'h4015, 8'h02);
    repeat (3) begin
      @(posedge clk);
      chk("no_trigger_rdy", {31'd0, o_rdy}, 32'd1);
    end

    start_xfer(8'h02, 0);
    finish_xfer("even_p02", 513);

    start_xfer(8'h02, 1);
    finish_xfer("odd_p02", ODD_HALT);

    start_xfer(8'hFF, 0);
    finish_xfer("page_ff", 513);

    // A second $4014 write mid-transfer must neither restart nor retarget.
    start_xfer(8'h02, 0);
    n = 0;
    while (wr_seen < 50 && n < 200) begin
      @(posedge clk);
      n++;
    end
    cpu_write(16'h4014, 8'h03);
    cpu_write(16'h4014, 8'h03);
    finish_xfer("ignore_retrigger", 513);

    // Asynchronous reset after 100 writes abandons the transfer.
    start_xfer(8'h02, 0);
    n = 0;
    while (wr_seen < 100 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("pre_reset_writes", wr_seen, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdy", {31'd0, o_rdy}, 32'd1);
    chk("abort_active", {31'd0, o_dma_active}, 32'd0);
    chk("abort_count", {23'd0, o_debug_count}, 32'd0);
    exp_dat.delete();
    exp_addr.delete();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("post_reset_writes", wr_seen, 100);
    chk("post_reset_rdy", {31'd0, o_rdy}, 32'd1);
    chk("post_reset_count", {23'd0, o_debug_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite DMA controller (CPU register $4014) sitting directly upstream of the PPU's OAM port. A CPU write of page number P halts the CPU via RDY. The block then masters the CPU bus and copies the 256 bytes at $P00–$PFF into the PPU by alternating reads from memory with writes to $2004 (OAMDATA). It runs on the CPU clock and returns the bus when the transfer completes.

## Interface
- No parameters.
- i_clk  input  1  CPU clock; all state updates on the negative edge, consistent with the PPU.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_address  input  16  CPU address bus, used for $4014 decode.
- i_rw  input  1  CPU read/~write (1 = read).
- i_data  input  8  CPU write data; carries the page number P.
- i_bus_data  input  8  memory read data while DMA masters the bus.
- o_rdy  output  1  CPU RDY; 0 halts the CPU.
- o_dma_active  output  1  1 = bus mux selects the DMA address/rw/data.
- o_address  output  16  DMA bus address.
- o_rw  output  1  DMA read/~write.
- o_data  output  8  DMA write data.
- o_debug_count  output  9  bytes written to OAM in the current transfer (0–256).

## Operation
- Trigger: sampled on a clock edge where i_address==16'h4014, i_rw==0 and state==IDLE. On trigger, r_page<=i_data and state<=HALT.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - o_rdy=1, o_dma_active=0, o_address=0, o_rw=1, o_data=0.
- HALT (1 cycle):
  - o_rdy=0, o_dma_active=1, o_rw=1, o_address={r_page,8'h00} (dummy read; data discarded).
  - Next state is ALIGN if r_parity==1 during HALT and the alignment feature is compiled in; otherwise READ.
- ALIGN (1 cycle): same outputs as HALT. Next state is READ.
- READ:
  - o_address={r_page,r_index}, o_rw=1.
  - r_byte<=i_bus_data at the end of the cycle; next state is WRITE.
- WRITE:
  - o_address=16'h2004, o_rw=0, o_data=r_byte.
  - r_index<=r_index+1 (8-bit, wraps) and r_count<=r_count+1.
  - If r_index==8'hFF, next state is IDLE; otherwise READ.
- r_parity: toggles every clock from reset, independent of state. Reset value 0.
- r_count: 9-bit. Cleared to 0 on trigger; holds 256 after completion until the next trigger.
- o_rdy and o_dma_active are low/high together in every non-IDLE state.

## Timing
- Reset (asynchronous, any state): state=IDLE, r_index=0, r_count=0, r_page=0, r_byte=0, r_parity=0. All outputs take their IDLE values immediately. A transfer in progress is abandoned; no further $2004 writes occur.
- o_rdy falls in the cycle after the trigger edge.
- Total halted cycles: 513 (HALT + 256×(READ,WRITE)), or 514 with ALIGN.
- o_rdy returns to 1 in the cycle after the final WRITE (index $FF).
- Write to $4014 while not IDLE: ignored. It does not restart the transfer and does not change r_page. (The CPU is halted, so this occurs only under test.)
- Page $FF: addresses $FF00–$FFFF. The index wraps only inside the page; the page never increments.
- Every $2004 write is exactly one cycle, always immediately preceded by its READ cycle.

## Configuration
- OAM_DMA_ODD_ALIGN_EN:
  - Defined: the ALIGN cycle is inserted when HALT falls on an odd parity cycle. Transfer takes 513 or 514 cycles, matching hardware.
  - Undefined: ALIGN is never entered; every transfer takes exactly 513 cycles. r_parity is still maintained.

## Test plan
- Reset then idle: o_rdy=1, o_dma_active=0, o_debug_count=0; writes to $4013/$4015 do not trigger.
- Memory $0200+i = i^8'h5A. Write $02 to $4014 on an even parity cycle. Required: 256 writes to $2004 carrying 8'h5A,8'h5B,…; o_rdy low for 513 cycles; o_debug_count=256.
- Same transfer triggered on an odd parity cycle with OAM_DMA_ODD_ALIGN_EN defined: o_rdy low for 514 cycles. Without the macro: 513 cycles.
- Write $FF to $4014: read addresses are $FF00..$FFFF in order; none reach $0000.
- Assert i_reset_n low after 100 $2004 writes: o_rdy=1 and o_dma_active=0 immediately; no further writes; o_debug_count=0.
- Drive a $4014 write with data $03 mid-transfer of page $02: the transfer continues reading $02xx and ends after 256 writes.
